// File: rtl/nbus_master.sv
// Native-bus initiator: one request at a time, decoded to per-slave CS_N with SETUP/STROBE/HOLD sequencing.
// Latency accept->rsp_valid: read 4, write 3+WR_CYCLES, error 1; req_ready low from accept until the cycle after the response.
module nbus_master #(
    parameter int NUM_SLV   = 4,
    parameter int WR_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [NUM_SLV-1:0]     CS_N,
    output logic                   RD_N,
    output logic                   WR_N,
    output logic [11:0]            Addr,
    output logic [31:0]            DataIn,
    input  logic [NUM_SLV*32-1:0]  s_rdata
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP, ERR} state_t;

    state_t               state;
    logic                 we_q;
    logic [3:0]           idx_q;
    logic [3:0]           wr_cnt;
    logic [31:0]          rd_hold;
    logic                 req_hit;
    logic [NUM_SLV-1:0]   cs_dec;
    logic [31:0]          slv_rdata;

    always_comb begin
        req_hit = (req_addr[31:16] == 16'h8000) &&
                  (32'(req_addr[15:12]) < NUM_SLV) &&
                  (req_addr[1:0] == 2'b00);
        cs_dec    = '1;
        slv_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            cs_dec[k] = (req_addr[15:12] != 4'(k));
            if (idx_q == 4'(k))
                slv_rdata = s_rdata[32*k +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wr_cnt    <= '0;
            rd_hold   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            CS_N      <= '1;
            RD_N      <= 1'b1;
            WR_N      <= 1'b1;
            Addr      <= '0;
            DataIn    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        idx_q     <= req_addr[15:12];
                        if (req_hit) begin
                            state  <= SETUP;
                            CS_N   <= cs_dec;
                            Addr   <= req_addr[11:0];
                            DataIn <= req_we ? req_wdata : 32'h0;
                        end else begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    if (we_q) begin
                        WR_N   <= 1'b0;
                        wr_cnt <= 4'(WR_CYCLES - 1);
                    end else begin
                        RD_N <= 1'b0;
                    end
                end
                STROBE: begin
                    // Slaves clear status on every RD_N-low cycle, so capture exactly once here.
                    if (!we_q) begin
                        rd_hold <= slv_rdata;
                        RD_N    <= 1'b1;
                        state   <= HOLD;
                    end else if (wr_cnt == 4'd0) begin
                        WR_N  <= 1'b1;
                        state <= HOLD;
                    end else begin
                        wr_cnt <= wr_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state     <= RESP;
                    CS_N      <= '1;
                    Addr      <= '0;
                    DataIn    <= '0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? 32'h0 : rd_hold;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                end
                ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nbus_master.sv
// Directed + random bench for nbus_master with a cycle-stamped response scoreboard.
module tb_nbus_master;
    localparam int NS  = 4;
    localparam int WRC = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_we = 1'b0;
    logic [31:0]        req_addr = '0;
    logic [31:0]        req_wdata = '0;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [NS-1:0]      CS_N;
    logic               RD_N;
    logic               WR_N;
    logic [11:0]        Addr;
    logic [31:0]        DataIn;
    logic [NS*32-1:0]   s_rdata = '0;

    nbus_master #(.NUM_SLV(NS), .WR_CYCLES(WRC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N), .Addr(Addr), .DataIn(DataIn),
        .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic        we;
        logic [31:0] rdata;
        int          rdc;
        int          wrc;
        int          csc;
        logic [3:0]  cs;
        logic [11:0] addr;
        logic [31:0] din;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic fixed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int c, input int k);
        if (fixed) return (k == 2) ? 32'h0000_0155 : (32'hDEAD_0000 | 32'(k));
        return {4'(k), 12'hA5C, 16'(c)} ^ {16'(c * 7), 16'h0};
    endfunction

    // Slave data changes every cycle so a mistimed capture shows up.
    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = pat(cyc, k);
    end

    int         rdc_m = 0, wrc_m = 0, csc_m = 0, rd_cyc = 0;
    logic [3:0] cs_seen = 4'hF;
    exp_t       e;

    always @(negedge clk) begin
        if (reset) begin
            rdc_m = 0; wrc_m = 0; csc_m = 0; cs_seen = 4'hF;
        end else begin
            chk("cs_onehot", 32'($countones(~CS_N) <= 1), 32'd1);
            chk("strobe_excl", {31'b0, RD_N | WR_N}, 32'd1);
            chk("strobe_needs_cs", {31'b0, (RD_N && WR_N) || (CS_N != 4'hF)}, 32'd1);
            if (!RD_N) begin rdc_m++; rd_cyc = cyc; end
            if (!WR_N) wrc_m++;
            if (CS_N != 4'hF) begin
                csc_m++;
                cs_seen = CS_N;
                if (q.size() > 0) begin
                    chk("addr_held", {20'b0, Addr}, {20'b0, q[0].addr});
                    chk("datain_held", DataIn, q[0].din);
                end else begin
                    chk("cs_idle", {28'b0, CS_N}, 32'hF);
                end
            end
            if (q.size() == 0) begin
                chk("rsp_spurious", {31'b0, rsp_valid}, 32'd0);
            end else if (rsp_valid) begin
                e = q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rd_low_cycles", 32'(rdc_m), 32'(e.rdc));
                chk("wr_low_cycles", 32'(wrc_m), 32'(e.wrc));
                chk("cs_low_cycles", 32'(csc_m), 32'(e.csc));
                chk("cs_value", {28'b0, cs_seen}, {28'b0, e.cs});
                if (!e.err && !e.we) chk("rd_capture_cycle", 32'(rd_cyc), 32'(e.cyc - 2));
                rdc_m = 0; wrc_m = 0; csc_m = 0; cs_seen = 4'hF;
            end
            if (!rsp_valid) begin
                chk("rdata_idle", rsp_rdata, 32'd0);
                chk("err_idle", {31'b0, rsp_err}, 32'd0);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int acc);
        exp_t x;
        logic hit;
        int   lat;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        acc = -1;
        for (int n = 0; n < 40; n++) begin
            if (req_ready) begin
                acc = cyc + 1;
                hit = (addr[31:16] == 16'h8000) && (addr[15:12] < 4'(NS)) && (addr[1:0] == 2'b00);
                lat = !hit ? 1 : (we ? 3 + WRC : 4);
                x.cyc   = acc + lat - 1;
                x.err   = !hit;
                x.we    = we;
                x.rdata = (hit && !we) ? pat(acc + 1, int'(addr[15:12])) : 32'h0;
                x.rdc   = (hit && !we) ? 1 : 0;
                x.wrc   = (hit && we) ? WRC : 0;
                x.csc   = !hit ? 0 : (we ? 2 + WRC : 3);
                x.cs    = hit ? ~(4'b0001 << addr[15:12]) : 4'hF;
                x.addr  = hit ? addr[11:0] : 12'h0;
                x.din   = (hit && we) ? wd : 32'h0;
                q.push_back(x);
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            tests++; fails++;
            $error("FAIL accept_timeout: observed no accept expected accept for %h", addr);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    int a1, a2;
    logic [31:0] ra;

    initial begin
        #2 reset = 1'b1;
        #2;
        chk("rst_cs", {28'b0, CS_N}, 32'hF);
        chk("rst_rd", {31'b0, RD_N}, 32'd1);
        chk("rst_wr", {31'b0, WR_N}, 32'd1);
        chk("rst_addr", {20'b0, Addr}, 32'd0);
        chk("rst_datain", DataIn, 32'd0);
        chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        fixed = 1'b1;
        send(1'b0, 32'h8000_2004, 32'h0, a1);
        drain();
        fixed = 1'b0;
        @(negedge clk);

        send(1'b1, 32'h8000_200C, 32'h0000_0040, a1);
        drain();

        send(1'b0, 32'h8000_5000, 32'h0, a1);
        send(1'b1, 32'h1000_0000, 32'h1234, a1);
        send(1'b0, 32'h8000_2002, 32'h0, a1);
        drain();

        send(1'b0, 32'h8000_1008, 32'h0, a1);
        send(1'b1, 32'h8000_3010, 32'hCAFE_F00D, a2);
        chk("b2b_accept", 32'(a2), 32'(a1 + 5));
        drain();

        send(1'b1, 32'h8000_0020, 32'h5555_AAAA, a1);
        for (int n = 0; n < 10; n++) begin
            if (!WR_N) break;
            @(negedge clk);
        end
        chk("wr_low_before_rst", {31'b0, WR_N}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("abort_wr", {31'b0, WR_N}, 32'd1);
        chk("abort_cs", {28'b0, CS_N}, 32'hF);
        chk("abort_rsp", {31'b0, rsp_valid}, 32'd0);
        q.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("ready_after_abort", {31'b0, req_ready}, 32'd1);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = {16'h8000, 4'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)), 2'b00};
            send(1'($urandom_range(0, 1)), ra, $urandom, a1);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nbus_master.md
Name: nbus_master

Overview:
- Native-bus initiator. It sits between the CPU data-memory port and the memory-mapped peripherals (GPIO, timer, UART, ...) in the 0x8000_xxxx window.
- It accepts one word request at a time over a valid/ready handshake, then decodes the peripheral index into a per-slave active-low chip select.
- It sequences the CS_N/RD_N/WR_N strobes with fixed setup and hold cycles, captures read data, and returns a single-cycle response to the pipeline, which stalls until that response arrives.

Parameters:
- NUM_SLV, 4, number of peripheral slots; slot k is at 0x8000_0000 + k*0x1000.
- WR_CYCLES, 1, number of cycles WR_N is held low per write (legal range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  initiator can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  decode or alignment error; qualified by rsp_valid.
- CS_N  output  NUM_SLV  per-slave chip select, active low.
- RD_N  output  1  read strobe, active low, shared by all slaves.
- WR_N  output  1  write strobe, active low, shared by all slaves.
- Addr  output  12  slave register offset.
- DataIn  output  32  write data to slaves.
- s_rdata  input  NUM_SLV*32  slave DataOut buses concatenated; slot k occupies bits [32k+31:32k].

Behaviour:
- Reset (asynchronous, immediate) sets:
  - FSM to IDLE;
  - CS_N to all 1s;
  - RD_N and WR_N to 1;
  - Addr, DataIn, rsp_rdata to 0;
  - rsp_valid and rsp_err to 0;
  - req_ready to 1 once reset is released.
- All bus outputs are registered; no combinational path from req_* to the bus.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - req_addr, req_we and req_wdata are latched on acceptance and may change afterwards.
- Decode, using the latched address:
  - Hit when addr[31:16] == 16'h8000 and addr[15:12] < NUM_SLV and addr[1:0] == 0.
  - The slave index is addr[15:12].
  - Addr output is addr[11:0].
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP, ERR.
- IDLE:
  - On accept of a hit, go to SETUP.
  - On accept of a miss, go to ERR.
- SETUP (1 cycle):
  - CS_N[idx] = 0; all other CS_N bits = 1.
  - Addr is valid; DataIn = wdata for writes, 0 for reads.
  - RD_N = WR_N = 1.
- STROBE:
  - CS_N, Addr and DataIn are held.
  - Read: RD_N = 0 for exactly 1 cycle. s_rdata[idx] is registered into the read-data holding register at the end of that cycle. This is mandatory: slaves clear status on every cycle RD_N is low.
  - Write: WR_N = 0 for WR_CYCLES cycles, counted by a 4-bit counter.
- HOLD (1 cycle):
  - Strobes are 1; CS_N[idx], Addr and DataIn are held.
- RESP (1 cycle):
  - CS_N is all 1s; Addr and DataIn return to 0.
  - rsp_valid = 1, rsp_err = 0.
  - rsp_rdata = captured data for reads, 0 for writes.
  - Next state is IDLE.
- ERR (1 cycle):
  - No strobe or chip select is ever asserted.
  - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - Next state is IDLE.
- rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.
- Latency from the accept edge to the rsp_valid cycle:
  - read: 4 cycles;
  - write: 3 + WR_CYCLES cycles;
  - error: 1 cycle.
- Back-to-back: the earliest next accept is the cycle after RESP/ERR (req_ready rises in the cycle after rsp_valid). CS_N is therefore high for at least 2 cycles between transfers.
- At most one CS_N bit is low at any time. RD_N and WR_N are never low simultaneously, and never low while CS_N is all 1s.
- Reset mid-transfer aborts immediately: strobes and CS_N deassert, no response is issued for the aborted request, and the slave sees a truncated access.
- A request held while busy is not accepted; no queueing.

Test Plan:
- Read GPIO: req_addr=0x8000_2004, req_we=0, with s_rdata slot 2 = 0x0000_0155 → CS_N=4'b1011; RD_N low exactly 1 cycle; Addr=0x004; rsp_valid 4 cycles after accept with rsp_rdata=0x155, rsp_err=0.
- Write GPIO with WR_CYCLES=1 and WR_CYCLES=3: req_addr=0x8000_200C, req_wdata=0x0000_0040 → DataIn=0x40 from SETUP through HOLD; WR_N low 1 (resp latency 4) resp. 3 cycles (latency 6); rsp_rdata=0.
- Errors: addresses 0x8000_5000, 0x1000_0000 and 0x8000_2002 → rsp_valid and rsp_err 1 cycle after accept; CS_N stays 4'hF; RD_N and WR_N stay 1.
- Back-to-back: req_valid held high for a read followed by a write → second accept occurs in the cycle after the first rsp_valid; rsp_valid fires once per request; the one-hot CS_N invariant holds throughout.
- Reset asserted asynchronously while WR_N=0 → WR_N and CS_N go high without waiting for a clock edge; no rsp_valid; req_ready=1 after reset is released.
- Random traffic over all slots, with a scoreboard against a reference model → the read capture cycle matches the single RD_N cycle, and all latencies match the values above.
